// File: rtl/cache_fill_fsm_pkg.sv
// Shared constants and helpers for the cache block-fill controller.
package cache_fill_fsm_pkg;

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_FILL = 1'b1;

  localparam int WORD_BYTES            = 2;
  localparam int WORDS_PER_BLOCK_DFLT  = 8;

  function automatic int block_offset_w(input int words);
    return $clog2(WORD_BYTES * words);
  endfunction

  localparam int BLOCK_OFFSET_W = block_offset_w(WORDS_PER_BLOCK_DFLT);

  // Mask that clears the byte-within-block bits; callers slice to their address width.
  function automatic logic [31:0] block_align_mask(input int offset_w);
    logic [31:0] mask_v;
    mask_v = 32'hFFFF_FFFF << offset_w;
    return mask_v;
  endfunction

endpackage

// File: rtl/cache_fill_fsm_fill_word_counter.sv
// Word counter for one side of a block fill: enable-increment, synchronous clear,
// and a flag raised while the count equals TERMINAL.
module fill_word_counter #(
  parameter int CNT_W    = 4,
  parameter int TERMINAL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             at_terminal
);

  logic [CNT_W-1:0] cnt_r;

  // Count register: reset and clear dominate the increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt         = cnt_r;
  assign at_terminal = (cnt_r == CNT_W'(TERMINAL));

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: stalls the requester, streams one block from
// pipelined memory into the data array, then writes the tag/valid entry.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = WORDS_PER_BLOCK_DFLT,
  parameter int MEM_LATENCY     = 4,
  parameter int ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              memory_read,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [ADDR_W-1:0] fill_address,
  output logic              write_tag_array
);

  localparam int CNT_W    = $clog2(WORDS_PER_BLOCK) + 1;
  localparam int OFFSET_W = block_offset_w(WORDS_PER_BLOCK);
  localparam logic [31:0]       ALIGN_MASK_FULL = block_align_mask(OFFSET_W);
  localparam logic [ADDR_W-1:0] ALIGN_MASK      = ALIGN_MASK_FULL[ADDR_W-1:0];

  // The FSM counts valids rather than timing them, so latency only has to be sane.
  if (MEM_LATENCY < 1 || ADDR_W > 32 || ADDR_W <= OFFSET_W ||
      (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) begin : g_param_check
    $error("cache_fill_fsm: unsupported parameter combination");
  end

  logic              state_r;
  logic [ADDR_W-1:0] base_r;
  logic [CNT_W-1:0]  issue_cnt_s;
  logic [CNT_W-1:0]  recv_cnt_s;
  logic              issue_done_s;
  logic              recv_last_s;
  logic              in_fill_s;
  logic              miss_take_s;
  logic              rd_s;
  logic              wd_s;
  logic              tag_s;

  assign in_fill_s   = (state_r == STATE_FILL);
  assign miss_take_s = (state_r == STATE_IDLE) & miss_detected;
  assign rd_s        = in_fill_s & ~issue_done_s;
  assign wd_s        = in_fill_s & memory_data_valid;
  assign tag_s       = wd_s & recv_last_s;

  fill_word_counter #(.CNT_W(CNT_W), .TERMINAL(WORDS_PER_BLOCK)) u_issue_cnt (
    .clk         (clk),
    .rst         (rst),
    .clr         (miss_take_s),
    .en          (rd_s),
    .cnt         (issue_cnt_s),
    .at_terminal (issue_done_s)
  );

  fill_word_counter #(.CNT_W(CNT_W), .TERMINAL(WORDS_PER_BLOCK - 1)) u_recv_cnt (
    .clk         (clk),
    .rst         (rst),
    .clr         (miss_take_s),
    .en          (wd_s),
    .cnt         (recv_cnt_s),
    .at_terminal (recv_last_s)
  );

  // State and block base; a miss seen during FILL is left for the requester to re-present.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= STATE_IDLE;
      base_r  <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        STATE_IDLE: begin
          if (miss_detected) begin
            state_r <= STATE_FILL;
            base_r  <= miss_address & ALIGN_MASK;
          end else begin
            state_r <= STATE_IDLE;
            base_r  <= base_r;
          end
        end
        STATE_FILL: begin
          if (tag_s) begin
            state_r <= STATE_IDLE;
          end else begin
            state_r <= STATE_FILL;
          end
          base_r <= base_r;
        end
        default: begin
          state_r <= STATE_IDLE;
          base_r  <= {ADDR_W{1'b0}};
        end
      endcase
    end
  end

  // Outputs: busy stalls in the miss cycle itself; everything else is quiet outside FILL.
  always_comb begin
    fsm_busy         = in_fill_s | miss_take_s;
    memory_read      = 1'b0;
    memory_address   = {ADDR_W{1'b0}};
    write_data_array = 1'b0;
    fill_address     = {ADDR_W{1'b0}};
    write_tag_array  = 1'b0;
    if (in_fill_s) begin
      memory_read      = rd_s;
      memory_address   = base_r + ADDR_W'(issue_cnt_s) * ADDR_W'(WORD_BYTES);
      write_data_array = wd_s;
      fill_address     = base_r + ADDR_W'(recv_cnt_s) * ADDR_W'(WORD_BYTES);
      write_tag_array  = tag_s;
    end else begin
      memory_read      = 1'b0;
      write_data_array = 1'b0;
      write_tag_array  = 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: directed scenarios plus randomized fills,
// compared cycle by cycle against a behavioural model of one block fill.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        memory_read;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [15:0] fill_address;
  logic        write_tag_array;

  always #5 clk = ~clk;

  cache_fill_fsm #(.WORDS_PER_BLOCK(8), .MEM_LATENCY(4), .ADDR_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .memory_read       (memory_read),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .fill_address      (fill_address),
    .write_tag_array   (write_tag_array)
  );

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: a fill in progress, its block base, reads issued, words received.
  bit m_fill;
  int m_base, m_issued, m_recv;

  int dq[$];
  int last_due, cyc, rc;
  logic [31:0] gap_mask;
  bit chk_on;
  int tag_cnt, tag_cyc, data_cnt, rd_cnt, busy_cnt, last_rd, acc_cyc, acc_gap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    tag_cnt = 0; tag_cyc = -1; data_cnt = 0; rd_cnt = 0; busy_cnt = 0; last_rd = -1;
  endtask

  // One clock cycle: drive inputs after negedge, check outputs, advance the model.
  task automatic step(input logic miss, input logic [15:0] addr, input logic r,
                      input logic spur, input int jit, input bit gap);
    logic v;
    bit   e_busy, e_rd, e_wd, e_tag;
    int   e_ma, e_fa, due;
    @(negedge clk);
    if (!r && !m_fill && miss) rc = 0;
    v = 1'b0;
    if (gap) v = (rc < 32) ? gap_mask[rc] : 1'b0;
    else if (dq.size() > 0 && dq[0] <= cyc) begin
      v = 1'b1;
      void'(dq.pop_front());
    end
    if (spur && !m_fill) v = 1'b1;
    rst = r; miss_detected = miss; miss_address = addr; memory_data_valid = v;
    #1;
    e_busy = m_fill || miss;
    e_rd   = m_fill && (m_issued < 8);
    e_ma   = m_fill ? ((m_base + 2 * m_issued) % 65536) : 0;
    e_wd   = m_fill && v;
    e_fa   = m_fill ? ((m_base + 2 * m_recv) % 65536) : 0;
    e_tag  = e_wd && (m_recv == 7);
    if (chk_on) begin
      chk("busy",      {31'd0, fsm_busy},         {31'd0, e_busy});
      chk("mem_read",  {31'd0, memory_read},      {31'd0, e_rd});
      chk("mem_addr",  {16'd0, memory_address},   e_ma);
      chk("wr_data",   {31'd0, write_data_array}, {31'd0, e_wd});
      chk("fill_addr", {16'd0, fill_address},     e_fa);
      chk("wr_tag",    {31'd0, write_tag_array},  {31'd0, e_tag});
    end
    if (write_tag_array === 1'b1) begin tag_cnt++; tag_cyc = rc; end
    if (write_data_array === 1'b1) data_cnt++;
    if (memory_read === 1'b1) begin rd_cnt++; last_rd = int'(memory_address); end
    if (fsm_busy === 1'b1) busy_cnt++;
    if (e_rd && !gap) begin
      due = cyc + 4 + $urandom_range(0, jit);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      dq.push_back(due);
    end
    if (!r && !m_fill && miss) begin
      if (acc_cyc >= 0) acc_gap = cyc - acc_cyc;
      acc_cyc = cyc;
    end
    if (r) begin
      m_fill = 1'b0; m_base = 0; m_issued = 0; m_recv = 0;
    end else if (!m_fill) begin
      if (miss) begin
        m_fill = 1'b1; m_base = int'(addr) & 32'hFFF0; m_issued = 0; m_recv = 0;
      end
    end else begin
      if (e_rd) m_issued++;
      if (v) begin
        m_recv++;
        if (m_recv == 8) m_fill = 1'b0;
      end
    end
    cyc++; rc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] a;
    int jit;
    rst = 1'b1; miss_detected = 1'b0; miss_address = 16'h0000; memory_data_valid = 1'b0;
    chk_on = 1'b0; acc_cyc = -1; acc_gap = -1; last_due = 0; cyc = 0; rc = 0;
    gap_mask = 32'h0; m_fill = 1'b0; m_base = 0; m_issued = 0; m_recv = 0;
    clear_obs();

    step(1'b0, 16'h0, 1'b1, 1'b0, 0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 0, 1'b0);
    chk_on = 1'b1;
    repeat (2) step(1'b0, 16'h0, 1'b0, 1'b0, 0, 1'b0);

    // Basic fill, fixed latency 4.
    clear_obs();
    step(1'b1, 16'h1236, 1'b0, 1'b0, 0, 1'b0);
    repeat (15) step(1'b0, 16'h0, 1'b0, 1'b0, 0, 1'b0);
    chk("basic_tags", tag_cnt, 1);
    chk("basic_tag_cyc", tag_cyc, 12);
    chk("basic_data", data_cnt, 8);
    chk("basic_busy", busy_cnt, 13);
    chk("basic_last_rd", last_rd, 32'h123E);

    // Irregular memory: valids at fixed relative cycles.
    gap_mask = (32'd1 << 6) | (32'd1 << 9) | (32'd1 << 10) | (32'd1 << 14) |
               (32'd1 << 15) | (32'd1 << 20) | (32'd1 << 21) | (32'd1 << 25);
    clear_obs();
    step(1'b1, 16'h2468, 1'b0, 1'b0, 0, 1'b1);
    repeat (29) step(1'b0, 16'h0, 1'b0, 1'b0, 0, 1'b1);
    chk("gap_tags", tag_cnt, 1);
    chk("gap_tag_cyc", tag_cyc, 25);
    chk("gap_data", data_cnt, 8);
    chk("gap_busy", busy_cnt, 26);

    // Address wrap at the top of memory.
    clear_obs();
    step(1'b1, 16'hFFFF, 1'b0, 1'b0, 0, 1'b0);
    repeat (15) step(1'b0, 16'h0, 1'b0, 1'b0, 0, 1'b0);
    chk("wrap_reads", rd_cnt, 8);
    chk("wrap_last_rd", last_rd, 32'hFFFE);
    chk("wrap_tags", tag_cnt, 1);

    // Spurious valids while idle, miss toggling during the fill.
    clear_obs();
    repeat (4) step(1'b0, 16'h0, 1'b0, 1'b1, 0, 1'b0);
    chk("idle_spur_data", data_cnt, 0);
    step(1'b1, 16'h3A5C, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      step((i == 12) ? 1'b1 : ((i < 12) ? 1'($urandom_range(0, 1)) : 1'b0),
           16'($urandom), 1'b0, 1'b0, 0, 1'b0);
    end
    repeat (3) step(1'b0, 16'h0, 1'b0, 1'b1, 0, 1'b0);
    chk("spur_tags", tag_cnt, 1);
    chk("spur_data", data_cnt, 8);
    chk("spur_last_rd", last_rd, 32'h3A5E);

    // Reset in cycle 7 of a fill, then a clean fill.
    clear_obs();
    step(1'b1, 16'h1236, 1'b0, 1'b0, 0, 1'b0);
    repeat (6) step(1'b0, 16'h0, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 0, 1'b0);
    repeat (8) step(1'b0, 16'h0, 1'b0, 1'b0, 0, 1'b0);
    chk("rst_tags", tag_cnt, 0);
    chk("rst_data", data_cnt, 3);
    clear_obs();
    step(1'b1, 16'h0040, 1'b0, 1'b0, 0, 1'b0);
    repeat (15) step(1'b0, 16'h0, 1'b0, 1'b0, 0, 1'b0);
    chk("refill_tags", tag_cnt, 1);
    chk("refill_tag_cyc", tag_cyc, 12);
    chk("refill_last_rd", last_rd, 32'h004E);

    // Back-to-back misses with miss held high.
    clear_obs();
    step(1'b1, 16'h0100, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 1; i <= 25; i++) step(1'b1, 16'h0200, 1'b0, 1'b0, 0, 1'b0);
    repeat (3) step(1'b0, 16'h0, 1'b0, 1'b0, 0, 1'b0);
    chk("b2b_gap", acc_gap, 13);
    chk("b2b_tags", tag_cnt, 2);
    chk("b2b_data", data_cnt, 16);
    chk("b2b_busy", busy_cnt, 26);
    chk("b2b_last_rd", last_rd, 32'h020E);

    // Randomized fills with jittered memory and noisy miss/valid inputs.
    repeat (12) begin
      clear_obs();
      a = 16'($urandom);
      jit = $urandom_range(0, 3);
      step(1'b1, a, 1'b0, 1'b0, jit, 1'b0);
      repeat (40) step(m_fill ? 1'($urandom_range(0, 1)) : 1'b0, 16'($urandom), 1'b0,
                       1'($urandom_range(0, 1)), jit, 1'b0);
      chk("rand_tags", tag_cnt, 1);
      chk("rand_data", data_cnt, 8);
      chk("rand_last_rd", last_rd, ((int'(a) & 32'hFFF0) + 14) % 65536);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling controller between the pipeline's cache arrays (I-side or D-side, one instance each) and the multi-cycle main memory.
- On a cache miss it stalls the requesting stage and streams one 16-byte block (8 x 16-bit words) out of pipelined memory.
- It writes each returned word into the cache data array, then writes the tag/valid entry once the last word lands.
- The fetch stage and the memory stage both consume its busy output as a stall.

Parameters:
- WORDS_PER_BLOCK, 8, words per cache block; power of two; block is 2*WORDS_PER_BLOCK bytes.
- MEM_LATENCY, 4, cycles from memory_read assertion to matching memory_data_valid; informational only, the FSM counts valids and does not time them.
- ADDR_W, 16, byte-address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- miss_detected  input  1  cache lookup missed this cycle.
- miss_address  input  ADDR_W  byte address of the missing access.
- memory_data_valid  input  1  main memory presents a read word this cycle.
- fsm_busy  output  1  stall for the requesting stage.
- memory_read  output  1  issue a read of memory_address this cycle.
- memory_address  output  ADDR_W  word-aligned byte address of the issued read.
- write_data_array  output  1  write the returned word into the cache data array.
- fill_address  output  ADDR_W  byte address of the word being written into the data array.
- write_tag_array  output  1  write tag + valid for the block at fill_address.

Behaviour:
- States: IDLE, FILL. Registers: state, base (block-aligned address), issue_cnt and recv_cnt (each log2(WORDS_PER_BLOCK)+1 bits).
- Reset (synchronous): state=IDLE, base=0, both counters 0. All outputs 0 in the cycle after rst is sampled high.
- fsm_busy = (state==FILL) | (state==IDLE & miss_detected). This is combinational, so the pipeline stalls in the miss cycle itself.
- IDLE, miss_detected=1:
  - Latch base = miss_address with low log2(2*WORDS_PER_BLOCK) bits cleared.
  - Clear both counters; next state FILL.
  - No read is issued in this cycle.
- FILL, issue side:
  - memory_read = (issue_cnt < WORDS_PER_BLOCK).
  - memory_address = base + 2*issue_cnt.
  - issue_cnt increments on every cycle memory_read is high.
  - One read per cycle, back to back.
- FILL, return side:
  - write_data_array = memory_data_valid.
  - fill_address = base + 2*recv_cnt.
  - recv_cnt increments on each valid.
- Last word (valid while recv_cnt==WORDS_PER_BLOCK-1):
  - write_tag_array=1 in that same cycle, with fill_address still pointing inside the block.
  - Next state IDLE.
- Outputs are driven only in FILL. In IDLE, memory_read, write_data_array and write_tag_array are 0, and memory_address and fill_address are 0.
- Latency for WORDS_PER_BLOCK=8, MEM_LATENCY=4, miss in cycle 0:
  - Reads issued cycles 1..8.
  - Data writes cycles 5..12; tag write cycle 12.
  - fsm_busy high cycles 0..12; back in IDLE cycle 13.
- Boundary conditions:
  - memory_data_valid in IDLE is ignored.
  - Valids beyond the block are ignored; state has already left FILL.
  - miss_detected during FILL is ignored, including in the final cycle. The requester still misses and re-presents the miss in IDLE, or hits after the tag write.
  - Address arithmetic wraps modulo 2^ADDR_W (block 0xFFF0 reads 0xFFF0..0xFFFE).
  - rst during FILL abandons the fill with no tag write. Late valids arriving afterwards are ignored in IDLE.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=1'b0, FILL=1'b1);
  - WORD_BYTES=2;
  - block-offset width constant derived from WORDS_PER_BLOCK;
  - block-align mask function.
- One sub-module, fill_word_counter: an enable-increment counter with synchronous clear and a terminal-count flag. It is instantiated twice, for the issue side and the receive side.

Test Plan:
- Basic fill: miss at 0x1236 with a memory model of latency 4 -> reads 0x1230,0x1232..0x123E in cycles 1..8; write_data_array in cycles 5..12 with fill_address 0x1230..0x123E; write_tag_array only in cycle 12; fsm_busy cycles 0..12, low in cycle 13.
- Slow or irregular memory: valids gapped at cycles 6,9,10,14,15,20,21,25 -> exactly 8 data writes at those cycles, tag write in cycle 25, busy held until then.
- Wrap: miss at 0xFFFF -> base 0xFFF0, last read 0xFFFE, no carry into issue of 0x0000.
- Spurious inputs: valid pulses while IDLE, and miss_detected toggling during FILL -> no writes in IDLE, base unchanged, exactly one tag write per fill.
- Reset mid-fill: rst at cycle 7 of the basic fill -> cycle 8 all outputs 0, state IDLE, no tag write. Remaining valids ignored; a new miss at 0x0040 fills cleanly.
- Back-to-back misses: miss held high continuously, addresses 0x0100 then 0x0200 -> second fill starts in IDLE cycle 13 (reads from cycle 14), no overlap with the first.
